// File: rtl/spi_fsm_if.sv
// SPI slave control bundle: conditioned SCLK/CS inputs toward the FSM
// and the enables the FSM drives back to the datapath.
//   master : SPI front end / datapath side (drives edges, cs_n, rw_bit)
//   slave  : spi_fsm side (drives addr_we, sr_we, dm_we, miso_buff, busy)
//   abort_count (8b) present only with SPI_FSM_ABORT_CNT_EN defined.
interface spi_fsm_if;
    logic       sclk_pos_edge;
    logic       sclk_neg_edge;
    logic       cs_n;
    logic       rw_bit;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_buff;
    logic       busy;
`ifdef SPI_FSM_ABORT_CNT_EN
    logic [7:0] abort_count;

    modport master (
        output sclk_pos_edge, sclk_neg_edge, cs_n, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff, busy, abort_count
    );
    modport slave (
        input  sclk_pos_edge, sclk_neg_edge, cs_n, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff, busy, abort_count
    );
`else
    modport master (
        output sclk_pos_edge, sclk_neg_edge, cs_n, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff, busy
    );
    modport slave (
        input  sclk_pos_edge, sclk_neg_edge, cs_n, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff, busy
    );
`endif
endinterface

// File: rtl/spi_fsm.sv
// SPI slave transaction controller: Moore FSM sequencing address capture,
// read load/shift-out and write capture/store for one SPI transaction.
// Ports: clk, reset_n (async, active low), bus (spi_fsm_if.slave).
// Option: SPI_FSM_ABORT_CNT_EN adds bus.abort_count, a saturating count
// of transactions aborted by cs_n rising mid-transfer.
module spi_fsm #(
    parameter int width = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    spi_fsm_if.slave bus
);

    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(width);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SEND,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          addr_we_q, sr_we_q, dm_we_q, miso_q, busy_q;

    // cs_n high overrides everything, including a coincident SCLK edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GET_ADDR;
                    cnt_d   = '0;
                end
                GET_ADDR: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = GOT_ADDR;
                        cnt_d   = '0;
                    end else if (bus.sclk_pos_edge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GOT_ADDR: begin
                    state_d = bus.rw_bit ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    state_d = READ_SEND;
                end
                READ_SEND: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else if (bus.sclk_neg_edge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITE_GET: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = WRITE_STORE;
                        cnt_d   = '0;
                    end else if (bus.sclk_pos_edge) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITE_STORE: begin
                    state_d = DONE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered alongside the state from the same next-state
    // value, so they always equal a decode of state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_we_q <= 1'b0;
            sr_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_we_q <= (state_d == GOT_ADDR);
            sr_we_q   <= (state_d == READ_LOAD);
            dm_we_q   <= (state_d == WRITE_STORE);
            miso_q    <= (state_d == READ_SEND);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.addr_we   = addr_we_q;
    assign bus.sr_we     = sr_we_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.miso_buff = miso_q;
    assign bus.busy      = busy_q;

`ifdef SPI_FSM_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;
    logic       abort;

    // Leaving IDLE or DONE on cs_n high is normal, not an abort.
    assign abort = bus.cs_n && (state_q != IDLE) && (state_q != DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_cnt_q <= '0;
        end else if (abort && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_q <= abort_cnt_q + 8'd1;
        end
    end

    assign bus.abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: expected enable pulses are queued as each
// transaction is driven and consumed by a monitor as the DUT emits them.
module tb_spi_fsm;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   exp_ab;

    localparam logic [2:0] EV_A = 3'b100;
    localparam logic [2:0] EV_S = 3'b010;
    localparam logic [2:0] EV_D = 3'b001;

    logic [2:0] exp_q[$];
    logic [2:0] mon_ev;
    logic [2:0] mon_exp;

    spi_fsm_if bus ();

    spi_fsm #(.width(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pos_pulse();
        bus.sclk_pos_edge = 1'b1;
        tick();
        bus.sclk_pos_edge = 1'b0;
        tick();
    endtask

    task automatic neg_pulse();
        bus.sclk_neg_edge = 1'b1;
        tick();
        bus.sclk_neg_edge = 1'b0;
        tick();
    endtask

    // Starts a transaction and shifts the address byte; ends in GOT_ADDR.
    task automatic addr_phase(input logic rw);
        bus.cs_n   = 1'b0;
        bus.rw_bit = rw;
        tick();
        for (int i = 0; i < 7; i++) pos_pulse();
        chk("addr_no_en_early",
            {5'd0, bus.addr_we, bus.sr_we, bus.dm_we}, 8'd0);
        pos_pulse();
        chk("addr_we_pulse", {7'd0, bus.addr_we}, 8'd1);
    endtask

    // Every enable pulse the DUT emits must match the next queued one.
    always @(negedge clk) begin
        mon_ev = {bus.addr_we, bus.sr_we, bus.dm_we};
        if (mon_ev !== 3'b000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_enable: observed %b expected none",
                       mon_ev);
            end else begin
                mon_exp = exp_q.pop_front();
                assert (mon_ev === mon_exp) else begin
                    n_fail++;
                    $error("FAIL enable_seq: observed %b expected %b",
                           mon_ev, mon_exp);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_ab  = 0;
        reset_n = 1'b0;
        bus.sclk_pos_edge = 1'b0;
        bus.sclk_neg_edge = 1'b0;
        bus.cs_n   = 1'b1;
        bus.rw_bit = 1'b0;
        #1;
        chk("reset_busy", {7'd0, bus.busy}, 8'd0);
        chk("reset_miso", {7'd0, bus.miso_buff}, 8'd0);
        chk("reset_en",
            {5'd0, bus.addr_we, bus.sr_we, bus.dm_we}, 8'd0);
`ifdef SPI_FSM_ABORT_CNT_EN
        chk("reset_abort_cnt", bus.abort_count, 8'd0);
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_busy", {7'd0, bus.busy}, 8'd0);

        // Write transaction, then extra edges in DONE.
        exp_q.push_back(EV_A);
        exp_q.push_back(EV_D);
        addr_phase(1'b0);
        tick();
        chk("wr_get_busy", {7'd0, bus.busy}, 8'd1);
        for (int i = 0; i < 7; i++) pos_pulse();
        chk("wr_no_dm_early", {7'd0, bus.dm_we}, 8'd0);
        pos_pulse();
        chk("wr_dm_we", {7'd0, bus.dm_we}, 8'd1);
        tick();
        chk("wr_done_busy", {7'd0, bus.busy}, 8'd1);
        chk("wr_done_en",
            {4'd0, bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff}, 8'd0);
        for (int i = 0; i < 3; i++) pos_pulse();
        chk("done_extra_busy", {7'd0, bus.busy}, 8'd1);
        chk("done_extra_en",
            {5'd0, bus.addr_we, bus.sr_we, bus.dm_we}, 8'd0);
        bus.cs_n = 1'b1;
        tick();
        chk("wr_end_idle", {7'd0, bus.busy}, 8'd0);
`ifdef SPI_FSM_ABORT_CNT_EN
        chk("wr_abort_cnt", bus.abort_count, 8'(exp_ab));
`endif
        tick();

        // Read transaction.
        exp_q.push_back(EV_A);
        exp_q.push_back(EV_S);
        addr_phase(1'b1);
        tick();
        chk("rd_sr_we", {7'd0, bus.sr_we}, 8'd1);
        chk("rd_load_miso", {7'd0, bus.miso_buff}, 8'd0);
        tick();
        chk("rd_send_miso", {7'd0, bus.miso_buff}, 8'd1);
        for (int i = 0; i < 7; i++) neg_pulse();
        chk("rd_miso_7", {7'd0, bus.miso_buff}, 8'd1);
        neg_pulse();
        chk("rd_miso_off", {7'd0, bus.miso_buff}, 8'd0);
        chk("rd_done_busy", {7'd0, bus.busy}, 8'd1);
        bus.cs_n = 1'b1;
        tick();
        chk("rd_end_idle", {7'd0, bus.busy}, 8'd0);
        tick();

        // Abort during address phase.
        bus.cs_n   = 1'b0;
        bus.rw_bit = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) pos_pulse();
        chk("ab_busy_before", {7'd0, bus.busy}, 8'd1);
        bus.cs_n = 1'b1;
        exp_ab++;
        tick();
        chk("ab_idle", {7'd0, bus.busy}, 8'd0);
`ifdef SPI_FSM_ABORT_CNT_EN
        chk("ab_abort_cnt", bus.abort_count, 8'(exp_ab));
`endif
        tick();

        // Collision: pos edge together with cs_n rising in WRITE_GET.
        exp_q.push_back(EV_A);
        addr_phase(1'b0);
        tick();
        for (int i = 0; i < 3; i++) pos_pulse();
        bus.sclk_pos_edge = 1'b1;
        bus.cs_n = 1'b1;
        exp_ab++;
        tick();
        bus.sclk_pos_edge = 1'b0;
        chk("col_idle", {7'd0, bus.busy}, 8'd0);
`ifdef SPI_FSM_ABORT_CNT_EN
        chk("col_abort_cnt", bus.abort_count, 8'(exp_ab));
`endif
        tick();
        tick();
        chk("col_no_dm", {7'd0, bus.dm_we}, 8'd0);

        // Asynchronous reset during READ_SEND.
        exp_q.push_back(EV_A);
        exp_q.push_back(EV_S);
        addr_phase(1'b1);
        tick();
        tick();
        for (int i = 0; i < 3; i++) neg_pulse();
        chk("rst_pre_miso", {7'd0, bus.miso_buff}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_miso", {7'd0, bus.miso_buff}, 8'd0);
        chk("rst_async_busy", {7'd0, bus.busy}, 8'd0);
`ifdef SPI_FSM_ABORT_CNT_EN
        exp_ab = 0;
        chk("rst_abort_cnt", bus.abort_count, 8'd0);
`endif
        bus.cs_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst_wait_idle", {7'd0, bus.busy}, 8'd0);

        // Fresh write after reset completes normally.
        exp_q.push_back(EV_A);
        exp_q.push_back(EV_D);
        addr_phase(1'b0);
        tick();
        for (int i = 0; i < 8; i++) pos_pulse();
        chk("post_rst_dm_we", {7'd0, bus.dm_we}, 8'd1);
        tick();
        bus.cs_n = 1'b1;
        tick();
        chk("post_rst_idle", {7'd0, bus.busy}, 8'd0);
        tick();
        tick();

        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
